sram0_read_sched: RTL and testbench

SRAM0_READ_SCHED -- requirements
Module: sram0_read_sched

---
 rtl/sram0_read_sched.sv | 161 ++++++++++++++++
 tb/tb_sram0_read_sched.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram0_read_sched.sv
// SRAM0 read scheduler: issues IV/MV word reads and streams 16 value lanes per word.
// Optional stall-cycle counter (o_stall_cycles) enabled by defining SRAM0_SCHED_PERF_EN.
module sram0_read_sched #(
  parameter int unsigned ADDR_W       = 5,
  parameter int unsigned VAL_PER_WORD = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_abort,
  input  logic              i_stall,
  input  logic              i_load_iv,
  input  logic [ADDR_W-1:0] i_iv_addr,
  input  logic [ADDR_W-1:0] i_mv_base,
  input  logic [4:0]        i_num_words,
  output logic              o_read_start_IV,
  output logic              o_read_start_MV,
  output logic [ADDR_W-1:0] o_read_addr,
  output logic [7:0]        o_count,
  output logic              o_busy,
  output logic              o_done
`ifdef SRAM0_SCHED_PERF_EN
  ,
  output logic [15:0]       o_stall_cycles
`endif
);

  typedef enum logic [2:0] {StIdle, StIssue, StStream, StGap, StDone} state_e;

  localparam logic [3:0] LastLane = 4'(VAL_PER_WORD - 1);

  state_e            state_q, state_d;
  logic [4:0]        word_idx_q, word_idx_d;
  logic              load_iv_q, load_iv_d;
  logic [ADDR_W-1:0] iv_addr_q, iv_addr_d;
  logic [ADDR_W-1:0] mv_base_q, mv_base_d;
  logic [4:0]        num_words_q, num_words_d;
  logic [7:0]        count_q, count_d;
  logic              read_iv_q, read_iv_d;
  logic              read_mv_q, read_mv_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              lane_last;
  logic              last_word;

  assign lane_last = (count_q[3:0] == LastLane);
  assign last_word = ((word_idx_q + 5'd1) == num_words_q);

  always_comb begin
    state_d     = state_q;
    word_idx_d  = word_idx_q;
    load_iv_d   = load_iv_q;
    iv_addr_d   = iv_addr_q;
    mv_base_d   = mv_base_q;
    num_words_d = num_words_q;
    count_d     = count_q;

    case (state_q)
      StIdle: begin
        if (i_start) begin
          load_iv_d   = i_load_iv;
          iv_addr_d   = i_iv_addr;
          mv_base_d   = i_mv_base;
          num_words_d = i_num_words;
          word_idx_d  = 5'd0;
          count_d     = 8'd0;
          state_d     = (i_num_words == 5'd0) ? StDone : StIssue;
        end
      end
      StIssue: state_d = StStream;
      StStream: begin
        if (!i_stall) begin
          count_d = count_q + 8'd1;
          if (lane_last) state_d = last_word ? StDone : StGap;
        end
      end
      StGap: begin
        word_idx_d = word_idx_q + 5'd1;
        state_d    = StIssue;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Abort wins over stall and the lane-15 hand-off; the partial job state is simply dropped.
    if (i_abort && (state_q != StIdle)) begin
      state_d    = StIdle;
      count_d    = count_q;
      word_idx_d = word_idx_q;
    end

    // Outputs are registered from the next state so they line up with state_q.
    read_iv_d = (state_d == StIssue) && load_iv_d && (word_idx_d == 5'd0);
    read_mv_d = (state_d == StIssue) && !read_iv_d;
    addr_d    = addr_q;
    if (state_d != StIdle) begin
      addr_d = read_iv_d ? iv_addr_d : mv_base_d + ADDR_W'(word_idx_d);
    end
    busy_d = (state_d != StIdle);
    done_d = (state_d == StDone);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= StIdle;
      word_idx_q  <= '0;
      load_iv_q   <= 1'b0;
      iv_addr_q   <= '0;
      mv_base_q   <= '0;
      num_words_q <= '0;
      count_q     <= '0;
      read_iv_q   <= 1'b0;
      read_mv_q   <= 1'b0;
      addr_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      word_idx_q  <= word_idx_d;
      load_iv_q   <= load_iv_d;
      iv_addr_q   <= iv_addr_d;
      mv_base_q   <= mv_base_d;
      num_words_q <= num_words_d;
      count_q     <= count_d;
      read_iv_q   <= read_iv_d;
      read_mv_q   <= read_mv_d;
      addr_q      <= addr_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign o_read_start_IV = read_iv_q;
  assign o_read_start_MV = read_mv_q;
  assign o_read_addr     = addr_q;
  assign o_count         = count_q;
  assign o_busy          = busy_q;
  assign o_done          = done_q;

`ifdef SRAM0_SCHED_PERF_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if ((state_q == StIdle) && i_start) begin
      stall_cnt_d = 16'd0;
    end else if ((state_q == StStream) && i_stall && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) stall_cnt_q <= 16'd0;
    else       stall_cnt_q <= stall_cnt_d;
  end

  assign o_stall_cycles = stall_cnt_q;
`endif

endmodule

// File: tb/tb_sram0_read_sched.sv
// Scoreboard bench for sram0_read_sched: directed jobs push expected per-cycle outputs,
// a negedge monitor pops and compares whenever the block is busy, done or pulsing.
module tb_sram0_read_sched;

  logic       clk = 1'b0;
  logic       i_rst = 1'b1;
  logic       i_start = 1'b0;
  logic       i_abort = 1'b0;
  logic       i_stall = 1'b0;
  logic       i_load_iv = 1'b0;
  logic [4:0] i_iv_addr = '0;
  logic [4:0] i_mv_base = '0;
  logic [4:0] i_num_words = '0;
  logic       o_read_start_IV;
  logic       o_read_start_MV;
  logic [4:0] o_read_addr;
  logic [7:0] o_count;
  logic       o_busy;
  logic       o_done;
`ifdef SRAM0_SCHED_PERF_EN
  logic [15:0] o_stall_cycles;
`endif

  sram0_read_sched #(.ADDR_W(5), .VAL_PER_WORD(16)) dut (
    .i_clk          (clk),
    .i_rst          (i_rst),
    .i_start        (i_start),
    .i_abort        (i_abort),
    .i_stall        (i_stall),
    .i_load_iv      (i_load_iv),
    .i_iv_addr      (i_iv_addr),
    .i_mv_base      (i_mv_base),
    .i_num_words    (i_num_words),
    .o_read_start_IV(o_read_start_IV),
    .o_read_start_MV(o_read_start_MV),
    .o_read_addr    (o_read_addr),
    .o_count        (o_count),
    .o_busy         (o_busy),
`ifdef SRAM0_SCHED_PERF_EN
    .o_done         (o_done),
    .o_stall_cycles (o_stall_cycles)
`else
    .o_done         (o_done)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned cyc;
    logic        iv;
    logic        mv;
    logic        done;
    logic        chk;
    logic [4:0]  addr;
    logic [7:0]  count;
  } exp_t;

  exp_t        sb_q[$];
  int unsigned cyc = 0;
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int unsigned big = 32'hFFFF_FFFF;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic push(input int unsigned c, input int unsigned lim, input logic iv, input logic mv,
                      input logic done, input logic chk, input logic [4:0] a, input logic [7:0] n);
    exp_t e;
    if (c > lim) return;
    e.cyc = c; e.iv = iv; e.mv = mv; e.done = done; e.chk = chk; e.addr = a; e.count = n;
    sb_q.push_back(e);
  endtask

  // Expected cycle-by-cycle view of a job whose i_start is sampled at the end of cycle n.
  task automatic push_job(input int unsigned n, input logic load_iv, input logic [4:0] iv,
                          input logic [4:0] base, input int nw, input int stall_k,
                          input int stall_len, input int unsigned lim);
    int unsigned c;
    logic [4:0]  a;
    logic        first_iv;
    int          v;
    c = n + 1;
    if (nw == 0) begin
      push(c, lim, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 8'd0);
      return;
    end
    for (int w = 0; w < nw; w++) begin
      a        = base + 5'(w);
      first_iv = load_iv && (w == 0);
      push(c, lim, first_iv, !first_iv, 1'b0, 1'b1, first_iv ? iv : a, 8'(16 * w));
      c++;
      for (int k = 0; k < 16; k++) begin
        v = 16 * w + k;
        push(c, lim, 1'b0, 1'b0, 1'b0, 1'b1, a, 8'(v));
        c++;
        if (v == stall_k) begin
          for (int j = 0; j < stall_len; j++) begin
            push(c, lim, 1'b0, 1'b0, 1'b0, 1'b1, a, 8'(v));
            c++;
          end
        end
      end
      push(c, lim, 1'b0, 1'b0, (w == nw - 1), 1'b0, 5'd0, 8'd0);
      c++;
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (o_busy || o_done || o_read_start_IV || o_read_start_MV) begin
      n_cmp++;
      if (sb_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_activity @%0d: busy=%b iv=%b mv=%b done=%b addr=%0d cnt=%0d",
                 cyc, o_busy, o_read_start_IV, o_read_start_MV, o_done, o_read_addr, o_count);
      end else begin
        e = sb_q.pop_front();
        if (cyc != e.cyc || o_busy !== 1'b1 || o_read_start_IV !== e.iv ||
            o_read_start_MV !== e.mv || o_done !== e.done ||
            (e.chk && (o_read_addr !== e.addr || o_count !== e.count))) begin
          n_bad++;
          $display({"FAIL cycle_out: got cyc=%0d busy=%b iv=%b mv=%b done=%b addr=%0d cnt=%0d",
                    " expected cyc=%0d busy=1 iv=%b mv=%b done=%b addr=%0d cnt=%0d (chk=%b)"},
                   cyc, o_busy, o_read_start_IV, o_read_start_MV, o_done, o_read_addr, o_count,
                   e.cyc, e.iv, e.mv, e.done, e.addr, e.count, e.chk);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic start_job(input logic load_iv, input logic [4:0] iv, input logic [4:0] base,
                           input logic [4:0] nw);
    i_load_iv   = load_iv;
    i_iv_addr   = iv;
    i_mv_base   = base;
    i_num_words = nw;
    i_start     = 1'b1;
    tick(1);
    i_start     = 1'b0;
  endtask

  task automatic drain(input string name, input int limit);
    int i;
    i = 0;
    while (sb_q.size() != 0 && i < limit) begin
      tick(1);
      i++;
    end
    check(name, sb_q.size(), 0);
    sb_q.delete();
    tick(2);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_count"}, o_count, 0);
    check({tag, "_addr"}, o_read_addr, 0);
    check({tag, "_iv"}, o_read_start_IV, 0);
    check({tag, "_mv"}, o_read_start_MV, 0);
    check({tag, "_busy"}, o_busy, 0);
    check({tag, "_done"}, o_done, 0);
`ifdef SRAM0_SCHED_PERF_EN
    check({tag, "_stall_cycles"}, o_stall_cycles, 0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned n;
    tick(3);
    i_rst = 1'b0;
    check_all_zero("reset");

    // Single word with IV preload.
    n = cyc;
    push_job(n, 1'b1, 5'd3, 5'd8, 1, -1, 0, big);
    start_job(1'b1, 5'd3, 5'd8, 5'd1);
    drain("job1_complete", 100);

    // Three MV words wrapping the address; a stray i_start mid-job must be ignored.
    n = cyc;
    push_job(n, 1'b0, 5'd0, 5'd30, 3, -1, 0, big);
    start_job(1'b0, 5'd0, 5'd30, 5'd3);
    tick(4);
    i_num_words = 5'd0;
    i_load_iv   = 1'b1;
    i_start     = 1'b1;
    tick(1);
    i_start     = 1'b0;
    drain("job2_complete", 100);

    // Four stall cycles while o_count shows 5.
    n = cyc;
    push_job(n, 1'b1, 5'd2, 5'd4, 1, 5, 4, big);
    start_job(1'b1, 5'd2, 5'd4, 5'd1);
    tick(6);
    i_stall = 1'b1;
    tick(4);
    i_stall = 1'b0;
    drain("job3_complete", 100);
`ifdef SRAM0_SCHED_PERF_EN
    check("stall_cycles_4", o_stall_cycles, 4);
`endif

    // Abort together with stall on lane 15 of the first word.
    n = cyc;
    push_job(n, 1'b0, 5'd0, 5'd10, 2, -1, 0, n + 17);
    start_job(1'b0, 5'd0, 5'd10, 5'd2);
    tick(16);
    i_stall = 1'b1;
    i_abort = 1'b1;
    tick(1);
    i_stall = 1'b0;
    i_abort = 1'b0;
    check("abort_busy", o_busy, 0);
    check("abort_done", o_done, 0);
    tick(3);
    i_abort = 1'b1;
    tick(1);
    i_abort = 1'b0;
    check("idle_abort_busy", o_busy, 0);

    // A new job after the abort is accepted.
    n = cyc;
    push_job(n, 1'b0, 5'd0, 5'd20, 1, -1, 0, big);
    start_job(1'b0, 5'd0, 5'd20, 5'd1);
    drain("job5_complete", 100);
`ifdef SRAM0_SCHED_PERF_EN
    check("stall_cycles_cleared", o_stall_cycles, 0);
`endif

    // Reset mid-STREAM.
    n = cyc;
    push_job(n, 1'b1, 5'd7, 5'd12, 2, -1, 0, n + 8);
    start_job(1'b1, 5'd7, 5'd12, 5'd2);
    tick(7);
    i_rst = 1'b1;
    tick(1);
    i_rst = 1'b0;
    check_all_zero("midrst");
    check("midrst_sb_empty", sb_q.size(), 0);

    // Zero-word job: DONE straight away, no read pulses.
    n = cyc;
    push_job(n, 1'b1, 5'd5, 5'd9, 0, -1, 0, big);
    start_job(1'b1, 5'd5, 5'd9, 5'd0);
    drain("job_zero_complete", 20);

    // 17 words: o_count wraps past 255 back to 0 on word 16.
    n = cyc;
    push_job(n, 1'b1, 5'd31, 5'd0, 17, -1, 0, big);
    start_job(1'b1, 5'd31, 5'd0, 5'd17);
    drain("job_wrap_complete", 400);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
